// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter slice.
//
// Contents:
//   arb_state_t - sequencer states (IDLE -> ACCESS -> RESP -> IDLE)
//   PERF_CW     - width of each per-requester grant counter
//   sat_inc     - saturating increment used by the grant counters
//
// Optional feature macro used by this slice: DMEM_ARB_PERF_EN
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_t;

    localparam int PERF_CW = 16;

    // Counters stick at all-ones rather than wrapping back to zero.
    function automatic logic [PERF_CW-1:0] sat_inc(input logic [PERF_CW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
//
// Picks the lowest-indexed active request at or above ptr, wrapping back
// to index 0 when nothing at or above ptr is requesting.
//
// Ports:
//   req [N-1:0]  in   active requests
//   ptr [PW-1:0] in   index with highest priority this round
//   win [N-1:0]  out  one-hot winner (zero when no request)
//   idx [PW-1:0] out  binary index of the winner
//   any          out  at least one request is active
module rr_pick #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  win,
    output logic [PW-1:0] idx,
    output logic          any
);

    logic found;

    // Scan candidates in priority order starting at ptr. The inner loop
    // compares against constant indices, so every bit select of req is static.
    always_comb begin
        win   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < N; j++) begin
                if (!found && (j == ((int'(ptr) + k) % N)) && req[j]) begin
                    found  = 1'b1;
                    win[j] = 1'b1;
                    idx    = PW'(j);
                end
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter and sequencer in front of the 256x8 data
// memory. Shares the single memory port between NUM_REQ requesters, one
// access every three cycles (IDLE -> ACCESS -> RESP).
//
// Parameters: NUM_REQ (2..4), AW (address width), DW (data width).
//
// Ports:
//   clk, rst_n             clock; synchronous active-low reset
//   req/req_we             per-requester request and write select
//   req_addr/req_wdata     packed per-requester address / write data
//   gnt                    one-hot pulse while the access is on the memory
//   ack                    one-hot pulse when the access completes
//   rdata                  registered read data, held until the next read
//   mem_addr/mem_wdata     to memory
//   mem_we/mem_re          to memory, only active in ACCESS
//   mem_rdata              from memory (combinational read)
//   perf_cnt               only with DMEM_ARB_PERF_EN: 16-bit saturating
//                          grant counter per requester, requester i in
//                          [i*16 +: 16]
//
// Configuration macro: DMEM_ARB_PERF_EN
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int AW      = 8,
    parameter int DW      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    req_we,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    input  logic [NUM_REQ*DW-1:0] req_wdata,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [NUM_REQ-1:0]    ack,
    output logic [DW-1:0]         rdata,
    output logic [AW-1:0]         mem_addr,
    output logic [DW-1:0]         mem_wdata,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic [DW-1:0]         mem_rdata
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [NUM_REQ*PERF_CW-1:0] perf_cnt
`endif
);

    localparam int PW = (NUM_REQ > 2) ? 2 : 1;

    arb_state_t          state, state_nxt;
    logic [PW-1:0]       ptr;
    logic [PW-1:0]       lat_idx;
    logic                lat_we;
    logic [AW-1:0]       lat_addr;
    logic [DW-1:0]       lat_wdata;
    logic [DW-1:0]       rdata_q;

    logic [NUM_REQ-1:0]  pick_win;
    logic [PW-1:0]       pick_idx;
    logic                pick_any;
    logic                sel_we;
    logic [AW-1:0]       sel_addr;
    logic [DW-1:0]       sel_wdata;

    rr_pick #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_pick (
        .req (req),
        .ptr (ptr),
        .win (pick_win),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Route the winner's attributes through a one-hot mux so the latches
    // below only need to capture one set of values.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_win[i]) begin
                sel_we    = req_we[i];
                sel_addr  = req_addr[i*AW +: AW];
                sel_wdata = req_wdata[i*DW +: DW];
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: fixed three-cycle walk once a request is accepted.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   state_nxt = pick_any ? ST_ACCESS : ST_IDLE;
            ST_ACCESS: state_nxt = ST_RESP;
            ST_RESP:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Request latches, rotation pointer and read-data register. Inputs are
    // captured once in IDLE, so later changes on req lines cannot disturb
    // an access already under way.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr       <= '0;
            lat_idx   <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata_q   <= '0;
        end else begin
            if (state == ST_IDLE && pick_any) begin
                lat_idx   <= pick_idx;
                lat_we    <= sel_we;
                lat_addr  <= sel_addr;
                lat_wdata <= sel_wdata;
            end
            if (state == ST_ACCESS) begin
                if (!lat_we) begin
                    rdata_q <= mem_rdata;
                end
                if (int'(lat_idx) == NUM_REQ - 1) begin
                    ptr <= '0;
                end else begin
                    ptr <= lat_idx + PW'(1);
                end
            end
        end
    end

    // Output decode. mem_we is additionally gated by rst_n so that a reset
    // arriving while a write is on the memory prevents that write from
    // committing at the same edge.
    always_comb begin
        gnt       = '0;
        ack       = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (int'(lat_idx) == i) begin
                gnt[i] = (state == ST_ACCESS);
                ack[i] = (state == ST_RESP);
            end
        end
        if (state == ST_ACCESS) begin
            mem_addr  = lat_addr;
            mem_wdata = lat_wdata;
            mem_we    = lat_we & rst_n;
            mem_re    = ~lat_we;
        end
    end

    assign rdata = rdata_q;

`ifdef DMEM_ARB_PERF_EN
    logic [NUM_REQ-1:0][PERF_CW-1:0] perf_q;

    // One count per grant pulse, i.e. per cycle spent in ACCESS.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else if (state == ST_ACCESS) begin
            perf_q[lat_idx] <= sat_inc(perf_q[lat_idx]);
        end
    end

    assign perf_cnt = perf_q;
`endif

endmodule
